uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_param_if.sv | 28 ++
 rtl/uart_bit_timer.sv | 42 ++++
 rtl/uart_rx_param.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state type, parity modes
// and the default bit period for a 125 MHz clock.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // 125 MHz / 115200 baud, rounded to the nearest cycle
  localparam int CLKS_PER_BIT_DEFAULT = 1085;

endpackage

// File: rtl/uart_rx_param_if.sv
// Received-frame port of the UART receiver: payload, status flags and the
// consumer handshake.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  // Handshake: rx_valid high means rx_data and the flags hold a frame and stay
  // stable; the frame is consumed on a rising edge where rx_valid and rx_ready
  // are both high. A new frame arriving while rx_valid is high replaces the
  // held one and raises the sticky overrun flag.
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
    output rx_ready
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: loaded with a half or full bit period, emits a one-cycle
// tick when the period expires, then stops until loaded again.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load_half,
  input  logic load_full,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

  logic [CW-1:0] cnt;
  logic          run;

  assign tick = run && (cnt == '0);

  // A tick without a reload parks the timer at zero instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load_half) begin
      cnt <= HALF;
      run <= 1'b1;
    end else if (load_full) begin
      cnt <= FULL;
      run <= 1'b1;
    end else if (tick) begin
      run <= 1'b0;
    end else if (run) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: synchronises Rx, samples each bit at mid-period,
// checks parity/stop bits, detects breaks and holds the frame for the consumer.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic            CLOCK_125_p,
  input  logic            reset,
  input  logic            Rx,
  uart_rx_param_if.master rx_if,
  output uart_state_e     state_dbg
);

  localparam int BW = $clog2(DATA_BITS);

  logic [1:0]           sync_q;
  logic                 line;
  logic                 line_prev;
  logic                 fall;
  uart_state_e          state;
  uart_state_e          state_n;
  logic                 load_half;
  logic                 load_full;
  logic                 tick;
  logic                 frame_done;
  logic                 smp_data;
  logic                 smp_par;
  logic                 smp_stop;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 ferr_acc;
  logic                 zero_acc;
  logic                 brk_wait;
  logic                 perr_fin;
  logic                 ferr_fin;
  logic                 zero_fin;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 brk_q;
  logic                 ovr_q;
  logic                 accept;

  assign line      = sync_q[1];
  assign fall      = line_prev & ~line;
  assign state_dbg = state;
  assign accept    = valid_q & rx_if.rx_ready;

  always_ff @(posedge CLOCK_125_p or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      line_prev <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], Rx};
      line_prev <= line;
    end
  end

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (CLOCK_125_p),
    .rst       (reset),
    .load_half (load_half),
    .load_full (load_full),
    .tick      (tick)
  );

  always_ff @(posedge CLOCK_125_p or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    load_half  = 1'b0;
    load_full  = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        // After a break, keep re-arming the timer while the line is low so
        // only a full bit period of idle high releases the receiver.
        if (brk_wait) begin
          if (!line) load_full = 1'b1;
        end else if (fall) begin
          state_n   = ST_START;
          load_half = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!line) begin
            state_n   = ST_DATA;
            load_full = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          load_full = 1'b1;
          if (bit_cnt == BW'(DATA_BITS - 1))
            state_n = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (tick) begin
          load_full = 1'b1;
          state_n   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_n    = ST_IDLE;
            frame_done = 1'b1;
            load_full  = zero_fin;
          end else begin
            load_full = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign smp_data = (state == ST_DATA)   && tick;
  assign smp_par  = (state == ST_PARITY) && tick;
  assign smp_stop = (state == ST_STOP)   && tick;

  // Final flags include the stop sample taken in the completion cycle.
  assign ferr_fin = ferr_acc | ~line;
  assign zero_fin = zero_acc & ~line;

  always_comb begin
    perr_fin = 1'b0;
    if (PARITY_MODE == PAR_EVEN)     perr_fin = par_acc;
    else if (PARITY_MODE == PAR_ODD) perr_fin = ~par_acc;
  end

  always_ff @(posedge CLOCK_125_p or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      ferr_acc <= 1'b0;
      zero_acc <= 1'b0;
      brk_wait <= 1'b0;
    end else begin
      if (load_half) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        par_acc  <= 1'b0;
        ferr_acc <= 1'b0;
        zero_acc <= 1'b1;
      end
      if (smp_data) begin
        shreg    <= {line, shreg[DATA_BITS-1:1]};
        bit_cnt  <= bit_cnt + 1'b1;
        par_acc  <= par_acc ^ line;
        zero_acc <= zero_acc & ~line;
      end
      if (smp_par) begin
        par_acc  <= par_acc ^ line;
        zero_acc <= zero_acc & ~line;
      end
      if (smp_stop) begin
        stop_cnt <= stop_cnt + 1'b1;
        ferr_acc <= ferr_fin;
        zero_acc <= zero_fin;
      end
      if (frame_done && zero_fin)
        brk_wait <= 1'b1;
      else if (brk_wait && tick && line)
        brk_wait <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_125_p or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (frame_done) begin
      data_q  <= shreg;
      valid_q <= 1'b1;
      perr_q  <= perr_fin;
      ferr_q  <= ferr_fin;
      brk_q   <= zero_fin;
      if (valid_q && !rx_if.rx_ready) ovr_q <= 1'b1;
    end else if (accept) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.break_det  = brk_q;
  assign rx_if.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 and a 7E2 receiver driven with directed
// and random frames, checked against a frame-level model through exp queues.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic        clk;
  logic        rst;
  logic        rx_a;
  logic        rx_b;
  uart_state_e st_a;
  uart_state_e st_b;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [12:0] exp_q_a[$];
  logic [12:0] exp_q_b[$];
  logic [12:0] mon_e_a;
  logic [12:0] mon_e_b;
  logic [8:0]  r_data;
  logic [1:0]  r_stops;
  logic        r_flip;

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(7)) if_b ();

  uart_rx_param #(
    .DATA_BITS(8), .PARITY_MODE(PAR_NONE), .STOP_BITS(1), .CLKS_PER_BIT(CPB)
  ) dut_a (
    .CLOCK_125_p(clk), .reset(rst), .Rx(rx_a), .rx_if(if_a), .state_dbg(st_a)
  );

  uart_rx_param #(
    .DATA_BITS(7), .PARITY_MODE(PAR_EVEN), .STOP_BITS(2), .CLKS_PER_BIT(CPB)
  ) dut_b (
    .CLOCK_125_p(clk), .reset(rst), .Rx(rx_b), .rx_if(if_b), .state_dbg(st_b)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected result of one frame from its line contents: {ovr, brk, ferr, perr, data}
  function automatic logic [12:0] model_frame(input int nb, input int par, input int sb,
                                              input logic [8:0] data, input logic pbit,
                                              input logic [1:0] stops, input logic ovr);
    logic [8:0] d;
    int         ones;
    logic       perr;
    logic       ferr;
    logic       brk;
    d    = data & 9'((1 << nb) - 1);
    ones = $countones(d) + ((par != PAR_NONE) ? int'(pbit) : 0);
    if (par == PAR_EVEN)     perr = (ones % 2) == 1;
    else if (par == PAR_ODD) perr = (ones % 2) == 0;
    else                     perr = 1'b0;
    ferr = !stops[0] || (sb == 2 && !stops[1]);
    brk  = (ones == 0) && !stops[0] && (sb == 1 || !stops[1]);
    return {ovr, brk, ferr, perr, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input int sel, input logic b);
    if (sel == 0) rx_a = b;
    else          rx_b = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // flip inverts the correct parity bit; stops[i] is the level of stop bit i
  task automatic send_frame(input int sel, input logic [8:0] data, input logic flip,
                            input logic [1:0] stops, input logic push, input logic ovr);
    int   nb;
    int   par;
    int   sb;
    int   ones;
    logic pbit;
    nb   = (sel == 0) ? 8 : 7;
    par  = (sel == 0) ? PAR_NONE : PAR_EVEN;
    sb   = (sel == 0) ? 1 : 2;
    ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(data[i]);
    pbit = ((par == PAR_ODD) ? (ones % 2 == 0) : (ones % 2 == 1)) ^ flip;
    if (push) begin
      if (sel == 0) exp_q_a.push_back(model_frame(nb, par, sb, data, pbit, stops, ovr));
      else          exp_q_b.push_back(model_frame(nb, par, sb, data, pbit, stops, ovr));
    end
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(sel, data[i]);
    if (par != PAR_NONE) drive_bit(sel, pbit);
    for (int i = 0; i < sb; i++) drive_bit(sel, stops[i]);
  endtask

  // ---------------- scoreboard monitors ----------------
  always begin
    @(negedge clk);
    #1;
    if (!rst && if_a.rx_valid && if_a.rx_ready) begin
      check_eq("a_frame_expected", 32'(exp_q_a.size() != 0), 32'd1);
      if (exp_q_a.size() != 0) begin
        mon_e_a = exp_q_a.pop_front();
        check_eq("a_rx_data", 32'(if_a.rx_data), 32'(mon_e_a[7:0]));
        check_eq("a_ovr_brk_ferr_perr",
                 32'({if_a.overrun, if_a.break_det, if_a.frame_err, if_a.parity_err}),
                 32'(mon_e_a[12:9]));
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (!rst && if_b.rx_valid && if_b.rx_ready) begin
      check_eq("b_frame_expected", 32'(exp_q_b.size() != 0), 32'd1);
      if (exp_q_b.size() != 0) begin
        mon_e_b = exp_q_b.pop_front();
        check_eq("b_rx_data", 32'(if_b.rx_data), 32'(mon_e_b[6:0]));
        check_eq("b_ovr_brk_ferr_perr",
                 32'({if_b.overrun, if_b.break_det, if_b.frame_err, if_b.parity_err}),
                 32'(mon_e_b[12:9]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    if_a.rx_ready = 1'b1;
    if_b.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_a_data", 32'(if_a.rx_data), 32'd0);
    check_eq("rst_a_flags", 32'({if_a.rx_valid, if_a.overrun, if_a.break_det,
                                 if_a.frame_err, if_a.parity_err}), 32'd0);
    check_eq("rst_a_state", 32'(st_a), 32'(ST_IDLE));
    check_eq("rst_b_data", 32'(if_b.rx_data), 32'd0);
    check_eq("rst_b_flags", 32'({if_b.rx_valid, if_b.overrun, if_b.break_det,
                                 if_b.frame_err, if_b.parity_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // 8N1 basic frame
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b1, 1'b0);
    idle(CPB);

    // 7E2: both parity-bit values of 0x35, then a low second stop bit
    send_frame(1, 9'h035, 1'b0, 2'b11, 1'b1, 1'b0);
    idle(CPB);
    send_frame(1, 9'h035, 1'b1, 2'b11, 1'b1, 1'b0);
    idle(CPB);
    send_frame(1, 9'h035, 1'b0, 2'b01, 1'b1, 1'b0);
    idle(3 * CPB);

    // overrun: two frames held back, then a single acceptance
    if_a.rx_ready = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b11, 1'b0, 1'b0);
    send_frame(0, 9'h022, 1'b0, 2'b11, 1'b1, 1'b1);
    #1;
    check_eq("ovr_valid_held", 32'(if_a.rx_valid), 32'd1);
    check_eq("ovr_data_replaced", 32'(if_a.rx_data), 32'h22);
    check_eq("ovr_flag_set", 32'(if_a.overrun), 32'd1);
    @(negedge clk);
    if_a.rx_ready = 1'b1;
    @(negedge clk);
    if_a.rx_ready = 1'b0;
    #1;
    check_eq("ovr_valid_cleared", 32'(if_a.rx_valid), 32'd0);
    check_eq("ovr_flag_cleared", 32'(if_a.overrun), 32'd0);
    if_a.rx_ready = 1'b1;
    idle(CPB);

    // 6-cycle glitch is a false start
    rx_a = 1'b0;
    repeat (6) @(negedge clk);
    idle(2 * CPB);
    check_eq("glitch_state_idle", 32'(st_a), 32'(ST_IDLE));
    send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b1, 1'b0);
    idle(CPB);

    // break: 20 bit periods low, then an all-zero frame after a short high
    exp_q_a.push_back(model_frame(8, PAR_NONE, 1, 9'h000, 1'b0, 2'b00, 1'b0));
    rx_a = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    rx_a = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    send_frame(0, 9'h000, 1'b0, 2'b11, 1'b0, 1'b0);
    idle(2 * CPB);
    send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b1, 1'b0);
    idle(CPB);

    // reset in the 4th data bit of 0xFF
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_data", 32'(if_a.rx_data), 32'd0);
    check_eq("async_rst_flags", 32'({if_a.rx_valid, if_a.overrun, if_a.break_det,
                                     if_a.frame_err, if_a.parity_err}), 32'd0);
    check_eq("async_rst_state", 32'(st_a), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6 * CPB) @(negedge clk);
    send_frame(0, 9'h081, 1'b0, 2'b11, 1'b1, 1'b0);
    idle(CPB);

    // random frames on both receivers
    for (int i = 0; i < 24; i++) begin
      r_data  = 9'($urandom_range(0, 255));
      r_stops = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b11;
      send_frame(0, r_data, 1'b0, r_stops, 1'b1, 1'b0);
      idle(r_stops[0] ? int'($urandom_range(0, 20)) : 3 * CPB);

      r_data  = 9'($urandom_range(0, 127));
      r_flip  = 1'($urandom_range(0, 1));
      r_stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send_frame(1, r_data, r_flip, r_stops, 1'b1, 1'b0);
      idle((r_stops == 2'b11) ? int'($urandom_range(0, 20)) : 3 * CPB);
    end

    for (int t = 0; t < 400; t++) begin
      if (exp_q_a.size() == 0 && exp_q_b.size() == 0) break;
      @(negedge clk);
    end
    check_eq("a_frames_outstanding", 32'(exp_q_a.size()), 32'd0);
    check_eq("b_frames_outstanding", 32'(exp_q_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
